// File: rtl/multi_center_of_mass_if.sv
// ---------------------------------------------------------------------------
// multi_center_of_mass_if
// Pixel stream, end-of-frame strobe and centroid result bus for the
// multi-channel centre-of-mass engine.
//   master : pixel source / result consumer
//            drives x_in, y_in, valid_in, ch_mask_in, tabulate_in
//   slave  : centroid engine
//            drives x_out, y_out, area_out, found_out, valid_out,
//            busy_out, drop_out
// Per-channel results are packed with channel c at [c*W +: W].
// ---------------------------------------------------------------------------
interface multi_center_of_mass_if #(
   parameter int H_WIDTH = 11,
   parameter int V_WIDTH = 10,
   parameter int NUM_CH  = 2,
   parameter int CNT_W   = 21
);
   logic [H_WIDTH-1:0]        x_in;
   logic [V_WIDTH-1:0]        y_in;
   logic                      valid_in;
   logic [NUM_CH-1:0]         ch_mask_in;
   logic                      tabulate_in;
   logic [NUM_CH*H_WIDTH-1:0] x_out;
   logic [NUM_CH*V_WIDTH-1:0] y_out;
   logic [NUM_CH*CNT_W-1:0]   area_out;
   logic [NUM_CH-1:0]         found_out;
   logic                      valid_out;
   logic                      busy_out;
   logic                      drop_out;

   modport master (
      output x_in, y_in, valid_in, ch_mask_in, tabulate_in,
      input  x_out, y_out, area_out, found_out, valid_out, busy_out, drop_out
   );

   modport slave (
      input  x_in, y_in, valid_in, ch_mask_in, tabulate_in,
      output x_out, y_out, area_out, found_out, valid_out, busy_out, drop_out
   );
endinterface

// File: rtl/multi_center_of_mass.sv
// ---------------------------------------------------------------------------
// multi_center_of_mass
// Accumulates x/y coordinate sums and pixel counts for NUM_CH independent
// channels. On an accepted end-of-frame strobe the live accumulators are
// frozen into snapshot registers and a shared restoring divider computes
// each channel's centroid (x and y quotients in parallel), one channel after
// another, with a fixed latency regardless of the data.
// Ports:
//   clk_in   - clock, all logic on the rising edge
//   rst_n_in - asynchronous active-low reset
//   bus      - slave side of multi_center_of_mass_if (pixels in, results out)
// ---------------------------------------------------------------------------
module multi_center_of_mass #(
   parameter int H_WIDTH  = 11,
   parameter int V_WIDTH  = 10,
   parameter int NUM_CH   = 2,
   parameter int CNT_W    = 21,
   parameter int Y_LIMIT  = 317,
   parameter int MIN_AREA = 16
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   multi_center_of_mass_if.slave bus
);
   localparam int SUM_W = H_WIDTH + CNT_W;
   localparam int IT_W  = $clog2(SUM_W + 1);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_ITER = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [IT_W-1:0]    ITER_LAST = IT_W'(SUM_W - 1);
   localparam logic [CH_W-1:0]    CH_LAST   = CH_W'(NUM_CH - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]   MIN_A     = CNT_W'(MIN_AREA);
   localparam logic [V_WIDTH:0]   Y_LIM     = (V_WIDTH + 1)'(Y_LIMIT);

   // live and snapshot accumulators
   logic [NUM_CH-1:0][SUM_W-1:0] live_x, live_y, snap_x, snap_y, next_x, next_y;
   logic [NUM_CH-1:0][CNT_W-1:0] live_cnt, snap_cnt, next_cnt;
   logic [SUM_W-1:0]             x_ext, y_ext;
   logic                         pix_ok;
   logic                         accept;

   // sequencer and divider
   logic [1:0]                   state;
   logic                         busy;
   logic [CH_W-1:0]              ch;
   logic [IT_W-1:0]              iter;
   logic [CNT_W-1:0]             div_d;
   logic [CNT_W-1:0]             x_rem, y_rem, x_rem_n, y_rem_n;
   logic [SUM_W-1:0]             x_quo, y_quo, x_quo_n, y_quo_n;
   logic [CNT_W:0]               x_sh, y_sh, x_diff, y_diff;
   logic                         x_ge, y_ge;

   // results
   logic [NUM_CH-1:0][H_WIDTH-1:0] res_x, x_hold;
   logic [NUM_CH-1:0][V_WIDTH-1:0] res_y, y_hold;
   logic [NUM_CH-1:0][CNT_W-1:0]   area_hold;
   logic [NUM_CH-1:0]              found_n, found_hold;
   logic                           valid_pulse;
   logic                           drop_pulse;

   assign x_ext  = {{CNT_W{1'b0}}, bus.x_in};
   assign y_ext  = {{(SUM_W - V_WIDTH){1'b0}}, bus.y_in};
   assign pix_ok = bus.valid_in && ({1'b0, bus.y_in} < Y_LIM);
   assign accept = bus.tabulate_in && !busy;

   // Next live accumulator values; a saturated channel ignores the pixel so
   // its sums can never overflow SUM_W.
   always_comb begin
      next_x   = '0;
      next_y   = '0;
      next_cnt = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (pix_ok && bus.ch_mask_in[c] && (live_cnt[c] != CNT_MAX)) begin
            next_x[c]   = live_x[c] + x_ext;
            next_y[c]   = live_y[c] + y_ext;
            next_cnt[c] = live_cnt[c] + CNT_W'(1);
         end else begin
            next_x[c]   = live_x[c];
            next_y[c]   = live_y[c];
            next_cnt[c] = live_cnt[c];
         end
      end
   end

   // One restoring-division step for x and y sharing the same divisor.
   always_comb begin
      x_sh    = {x_rem, x_quo[SUM_W-1]};
      y_sh    = {y_rem, y_quo[SUM_W-1]};
      x_diff  = x_sh - {1'b0, div_d};
      y_diff  = y_sh - {1'b0, div_d};
      x_ge    = (x_sh >= {1'b0, div_d});
      y_ge    = (y_sh >= {1'b0, div_d});
      // a remainder is always below the divisor, so CNT_W bits suffice
      x_rem_n = x_ge ? x_diff[CNT_W-1:0] : x_sh[CNT_W-1:0];
      y_rem_n = y_ge ? y_diff[CNT_W-1:0] : y_sh[CNT_W-1:0];
      x_quo_n = {x_quo[SUM_W-2:0], x_ge};
      y_quo_n = {y_quo[SUM_W-2:0], y_ge};
   end

   // Found flag per channel from the frozen pixel count.
   always_comb begin
      found_n = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         found_n[c] = (snap_cnt[c] >= MIN_A) && (snap_cnt[c] != '0);
      end
   end

   // Live accumulation runs every cycle; an accepted strobe freezes the
   // frame (including a pixel on the same edge) and restarts from zero.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         live_x   <= '0;
         live_y   <= '0;
         live_cnt <= '0;
         snap_x   <= '0;
         snap_y   <= '0;
         snap_cnt <= '0;
      end else if (accept) begin
         snap_x   <= next_x;
         snap_y   <= next_y;
         snap_cnt <= next_cnt;
         live_x   <= '0;
         live_y   <= '0;
         live_cnt <= '0;
      end else begin
         live_x   <= next_x;
         live_y   <= next_y;
         live_cnt <= next_cnt;
      end
   end

   // Division sequencer: LOAD/ITER per channel, DONE publishes all results.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         ch          <= '0;
         iter        <= '0;
         div_d       <= '0;
         x_rem       <= '0;
         y_rem       <= '0;
         x_quo       <= '0;
         y_quo       <= '0;
         res_x       <= '0;
         res_y       <= '0;
         x_hold      <= '0;
         y_hold      <= '0;
         area_hold   <= '0;
         found_hold  <= '0;
         valid_pulse <= 1'b0;
         drop_pulse  <= 1'b0;
      end else begin
         valid_pulse <= 1'b0;
         drop_pulse  <= bus.tabulate_in && busy;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state <= S_LOAD;
                  busy  <= 1'b1;
                  ch    <= '0;
               end
            end
            S_LOAD: begin
               div_d <= snap_cnt[ch];
               x_quo <= snap_x[ch];
               y_quo <= snap_y[ch];
               x_rem <= '0;
               y_rem <= '0;
               iter  <= '0;
               state <= S_ITER;
            end
            S_ITER: begin
               x_quo <= x_quo_n;
               y_quo <= y_quo_n;
               x_rem <= x_rem_n;
               y_rem <= y_rem_n;
               iter  <= iter + IT_W'(1);
               if (iter == ITER_LAST) begin
                  // empty channel: quotient of a zero divisor is meaningless
                  res_x[ch] <= (div_d == '0) ? '0 : x_quo_n[H_WIDTH-1:0];
                  res_y[ch] <= (div_d == '0) ? '0 : y_quo_n[V_WIDTH-1:0];
                  if (ch == CH_LAST) begin
                     state <= S_DONE;
                  end else begin
                     ch    <= ch + CH_W'(1);
                     state <= S_LOAD;
                  end
               end
            end
            S_DONE: begin
               x_hold      <= res_x;
               y_hold      <= res_y;
               area_hold   <= snap_cnt;
               found_hold  <= found_n;
               valid_pulse <= 1'b1;
               busy        <= 1'b0;
               state       <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.x_out     = x_hold;
   assign bus.y_out     = y_hold;
   assign bus.area_out  = area_hold;
   assign bus.found_out = found_hold;
   assign bus.valid_out = valid_pulse;
   assign bus.busy_out  = busy;
   assign bus.drop_out  = drop_pulse;
endmodule

// File: tb/tb_multi_center_of_mass.sv
// ---------------------------------------------------------------------------
// tb_multi_center_of_mass
// Self-checking bench: a frame-level reference model (plain sums, counts and
// integer division, with a fixed-latency countdown) predicts every output on
// every cycle; directed frames pin the model with hand-computed values, then
// randomized pixel streams and strobes exercise it further.
// ---------------------------------------------------------------------------
module tb_multi_center_of_mass;
   localparam int H_W     = 11;
   localparam int V_W     = 10;
   localparam int NCH     = 2;
   localparam int CW      = 21;
   localparam int YLIM    = 317;
   localparam int MINA    = 16;
   localparam int LATENCY = NCH * (H_W + CW + 1) + 1;
   localparam longint CNTMAX = (64'd1 << CW) - 64'd1;

   logic clk;
   logic rst_n;

   multi_center_of_mass_if #(.H_WIDTH(H_W), .V_WIDTH(V_W), .NUM_CH(NCH), .CNT_W(CW)) bus ();

   multi_center_of_mass #(
      .H_WIDTH(H_W), .V_WIDTH(V_W), .NUM_CH(NCH), .CNT_W(CW),
      .Y_LIMIT(YLIM), .MIN_AREA(MINA)
   ) dut (
      .clk_in  (clk),
      .rst_n_in(rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   longint live_x [NCH];
   longint live_y [NCH];
   longint live_c [NCH];
   longint pend_x [NCH];
   longint pend_y [NCH];
   longint pend_a [NCH];
   longint pend_f [NCH];
   longint exp_x  [NCH];
   longint exp_y  [NCH];
   longint exp_a  [NCH];
   longint exp_f  [NCH];
   bit     exp_valid, exp_busy, exp_drop;
   int     remaining;

   task automatic check(input string name, input int c, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s[ch%0d] at %0t: got %0d, expected %0d", name, c, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         live_x[c] = 0; live_y[c] = 0; live_c[c] = 0;
         pend_x[c] = 0; pend_y[c] = 0; pend_a[c] = 0; pend_f[c] = 0;
         exp_x[c]  = 0; exp_y[c]  = 0; exp_a[c]  = 0; exp_f[c]  = 0;
      end
      exp_valid = 1'b0; exp_busy = 1'b0; exp_drop = 1'b0;
      remaining = 0;
   endtask

   // frame-level behaviour for one rising edge, from the inputs just sampled
   task automatic model_step();
      bit busy_before;
      bit pix;
      if (!rst_n) begin
         model_reset();
         return;
      end
      busy_before = (remaining > 0);
      exp_valid   = 1'b0;
      exp_drop    = bus.tabulate_in && busy_before;
      if (remaining > 0) begin
         remaining--;
         if (remaining == 0) begin
            exp_valid = 1'b1;
            for (int c = 0; c < NCH; c++) begin
               exp_x[c] = pend_x[c]; exp_y[c] = pend_y[c];
               exp_a[c] = pend_a[c]; exp_f[c] = pend_f[c];
            end
         end
      end
      pix = bus.valid_in && (int'(bus.y_in) < YLIM);
      for (int c = 0; c < NCH; c++) begin
         if (pix && bus.ch_mask_in[c] && live_c[c] < CNTMAX) begin
            live_x[c] += longint'(bus.x_in);
            live_y[c] += longint'(bus.y_in);
            live_c[c] += 1;
         end
      end
      if (bus.tabulate_in && !busy_before) begin
         for (int c = 0; c < NCH; c++) begin
            pend_x[c] = (live_c[c] == 0) ? 0 : (live_x[c] / live_c[c]) % (64'd1 << H_W);
            pend_y[c] = (live_c[c] == 0) ? 0 : (live_y[c] / live_c[c]) % (64'd1 << V_W);
            pend_a[c] = live_c[c];
            pend_f[c] = (live_c[c] >= MINA && live_c[c] != 0) ? 1 : 0;
            live_x[c] = 0; live_y[c] = 0; live_c[c] = 0;
         end
         remaining = LATENCY;
      end
      exp_busy = (remaining > 0);
   endtask

   task automatic compare_all();
      for (int c = 0; c < NCH; c++) begin
         check("x_out",     c, longint'(bus.x_out[c*H_W +: H_W]),   exp_x[c]);
         check("y_out",     c, longint'(bus.y_out[c*V_W +: V_W]),   exp_y[c]);
         check("area_out",  c, longint'(bus.area_out[c*CW +: CW]),  exp_a[c]);
         check("found_out", c, longint'(bus.found_out[c]),          exp_f[c]);
      end
      check("valid_out", 0, longint'(bus.valid_out), longint'(exp_valid));
      check("busy_out",  0, longint'(bus.busy_out),  longint'(exp_busy));
      check("drop_out",  0, longint'(bus.drop_out),  longint'(exp_drop));
   endtask

   // one clock: model on the rising edge, compare on the falling edge
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic drive(input bit v, input int x, input int y, input int m, input bit t);
      bus.valid_in    = v;
      bus.x_in        = H_W'(x);
      bus.y_in        = V_W'(y);
      bus.ch_mask_in  = NCH'(m);
      bus.tabulate_in = t;
   endtask

   task automatic idle();
      drive(1'b0, 0, 0, 0, 1'b0);
   endtask

   task automatic wait_valid(input int maxc, output int lat);
      bit seen;
      seen = 1'b0;
      lat  = 0;
      while (!seen && lat < maxc) begin
         cycle();
         lat++;
         if (bus.valid_out) seen = 1'b1;
      end
      if (!seen) check("valid_timeout", 0, 0, 1);
   endtask

   task automatic tab_and_wait(output int lat);
      drive(1'b0, 0, 0, 0, 1'b1);
      cycle();
      idle();
      wait_valid(200, lat);
   endtask

   function automatic longint dx(input int c); return longint'(bus.x_out[c*H_W +: H_W]); endfunction
   function automatic longint dy(input int c); return longint'(bus.y_out[c*V_W +: V_W]); endfunction
   function automatic longint da(input int c); return longint'(bus.area_out[c*CW +: CW]); endfunction

   initial begin
      int lat;
      int vcount;
      model_reset();
      idle();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      compare_all();
      repeat (3) cycle();
      rst_n = 1'b1;
      cycle();

      // single pixel on channel 0
      drive(1'b1, 100, 50, 1, 1'b0);
      cycle();
      tab_and_wait(lat);
      check("lit_latency", 0, lat, 67);
      check("lit_x", 0, dx(0), 100);
      check("lit_y", 0, dy(0), 50);
      check("lit_area", 0, da(0), 1);
      check("lit_found", 0, longint'(bus.found_out), 0);
      check("lit_area", 1, da(1), 0);

      // 16 pixels on channel 1, floor(120/16)
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, i, 200, 2, 1'b0);
         cycle();
      end
      tab_and_wait(lat);
      check("lit_x", 1, dx(1), 7);
      check("lit_y", 1, dy(1), 200);
      check("lit_area", 1, da(1), 16);
      check("lit_found", 1, longint'(bus.found_out), 2);

      // y limit boundary
      drive(1'b1, 40, 316, 3, 1'b0);
      cycle();
      drive(1'b1, 40, 317, 3, 1'b0);
      cycle();
      tab_and_wait(lat);
      for (int c = 0; c < NCH; c++) begin
         check("lit_area_ylim", c, da(c), 1);
         check("lit_y_ylim", c, dy(c), 316);
         check("lit_x_ylim", c, dx(c), 40);
      end

      // asynchronous reset twenty cycles into a division
      drive(1'b1, 300, 100, 3, 1'b0);
      cycle();
      tab_and_wait(lat);
      drive(1'b0, 0, 0, 0, 1'b1);
      cycle();
      idle();
      repeat (20) cycle();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("lit_rst_x", 0, dx(0), 0);
      check("lit_rst_area", 0, da(0), 0);
      check("lit_rst_busy", 0, longint'(bus.busy_out), 0);
      compare_all();
      repeat (2) cycle();
      rst_n = 1'b1;
      vcount = 0;
      for (int i = 0; i < 80; i++) begin
         cycle();
         if (bus.valid_out) vcount++;
      end
      check("lit_no_valid_after_rst", 0, vcount, 0);

      // drop while busy, then a third tabulate collects the in-between pixels
      drive(1'b1, 30, 20, 1, 1'b0);
      cycle();
      drive(1'b0, 0, 0, 0, 1'b1);
      cycle();
      lat = 0;
      for (int i = 1; i <= 9; i++) begin
         if (i <= 3) drive(1'b1, 8, 8, 1, 1'b0);
         else idle();
         cycle();
         lat++;
      end
      drive(1'b0, 0, 0, 0, 1'b1);
      cycle();
      lat++;
      check("lit_drop", 0, longint'(bus.drop_out), 1);
      idle();
      begin
         int more;
         wait_valid(200, more);
         check("lit_latency_drop", 0, lat + more, 67);
      end
      check("lit_x_first", 0, dx(0), 30);
      check("lit_y_first", 0, dy(0), 20);
      check("lit_area_first", 0, da(0), 1);
      tab_and_wait(lat);
      check("lit_x_third", 0, dx(0), 8);
      check("lit_y_third", 0, dy(0), 8);
      check("lit_area_third", 0, da(0), 3);

      // pixel on the same edge as the strobe closes the frame
      drive(1'b1, 5, 6, 1, 1'b1);
      cycle();
      idle();
      wait_valid(200, lat);
      check("lit_x_same", 0, dx(0), 5);
      check("lit_y_same", 0, dy(0), 6);
      check("lit_area_same", 0, da(0), 1);
      tab_and_wait(lat);
      check("lit_area_empty", 0, da(0), 0);
      check("lit_x_empty", 0, dx(0), 0);

      // randomized pixel streams and strobes
      for (int i = 0; i < 4000; i++) begin
         drive(($urandom_range(0, 1) == 1),
               int'($urandom_range(0, 2047)),
               int'($urandom_range(0, 400)),
               int'($urandom_range(0, 3)),
               ($urandom_range(0, 59) == 0));
         cycle();
      end
      idle();
      repeat (80) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/multi_center_of_mass.md
MULTI_CENTER_OF_MASS -- requirements
Module: multi_center_of_mass

Interface
REQ-001 SHALL have parameter H_WIDTH, default 11, x-coordinate width.
REQ-002 SHALL have parameter V_WIDTH, default 10, y-coordinate width.
REQ-003 SHALL have parameter NUM_CH, default 2, number of independent centroid channels.
REQ-004 SHALL have parameter CNT_W, default 21, per-channel pixel-count width.
REQ-005 SHALL have parameter Y_LIMIT, default 317; pixels with y_in >= Y_LIMIT ignored.
REQ-006 SHALL have parameter MIN_AREA, default 16, minimum count for found flag.
REQ-007 SHALL use derived width SUM_W = H_WIDTH + CNT_W for both sum accumulators.
REQ-008 clk_in  input  1  single clock, all logic on rising edge.
REQ-009 rst_n_in  input  1  asynchronous, active-low reset.
REQ-010 x_in  input  H_WIDTH  pixel x coordinate.
REQ-011 y_in  input  V_WIDTH  pixel y coordinate.
REQ-012 valid_in  input  1  pixel qualifier.
REQ-013 ch_mask_in  input  NUM_CH  bit c set = pixel belongs to channel c; multiple bits allowed.
REQ-014 tabulate_in  input  1  end-of-frame strobe.
REQ-015 x_out  output  NUM_CH*H_WIDTH  per-channel centroid x; channel c at bits [c*H_WIDTH +: H_WIDTH].
REQ-016 y_out  output  NUM_CH*V_WIDTH  per-channel centroid y, same packing.
REQ-017 area_out  output  NUM_CH*CNT_W  per-channel pixel count of the tabulated frame.
REQ-018 found_out  output  NUM_CH  bit c = area of channel c >= MIN_AREA and nonzero.
REQ-019 valid_out  output  1  one-cycle pulse: all result outputs updated.
REQ-020 busy_out  output  1  division engine active; tabulate not accepted.
REQ-021 drop_out  output  1  one-cycle pulse: tabulate_in rejected while busy.

Function
REQ-022 Accumulate: valid_in=1 and y_in < Y_LIMIT: each channel c with mask bit set adds x_in to xsum[c], y_in to ysum[c], 1 to cnt[c].
REQ-023 Count saturation: channel with cnt[c] = 2^CNT_W-1 SHALL ignore the pixel entirely (sums unchanged), guaranteeing no sum overflow.
REQ-024 Accumulation SHALL continue in every state, including while busy.
REQ-025 Tabulate accepted (tabulate_in=1, busy_out=0): same edge copies all live accumulators into snapshot registers and clears live accumulators; busy_out goes high.
REQ-026 valid_in and tabulate_in on same edge: the pixel SHALL be included in the snapshot (closing frame), not the new frame.
REQ-027 Tabulate while busy_out=1: ignored, drop_out pulses one cycle, live accumulation unaffected.
REQ-028 FSM states IDLE, LOAD, ITER, DONE. IDLE->LOAD on accepted tabulate; LOAD->ITER after 1 cycle; ITER runs SUM_W cycles; then LOAD of next channel, or DONE after channel NUM_CH-1; DONE->IDLE after 1 cycle.
REQ-029 Division: restoring radix-2, x and y quotients computed in parallel per channel, divisor cnt[c], floor quotient truncated to H_WIDTH / V_WIDTH.
REQ-030 Channel with cnt=0 SHALL still occupy its full slot (fixed latency); results forced x=0, y=0, found=0.
REQ-031 Latency: tabulate accepted at edge E0; valid_out high for exactly the cycle after edge E0 + NUM_CH*(SUM_W+1) + 1 (67 with defaults).
REQ-032 busy_out deasserts on the edge valid_out asserts; tabulate in the valid_out cycle SHALL be accepted.
REQ-033 Result outputs update only at valid_out and hold thereafter until the next valid_out.

Reset
REQ-034 rst_n_in low SHALL immediately clear all outputs, accumulators, snapshots and FSM (IDLE) without waiting for a clock.
REQ-035 Reset mid-division SHALL abort: no valid_out pulse, outputs zero.
REQ-036 First tabulate after reset release SHALL behave as from IDLE.

Verification
REQ-037 Single pixel x=100,y=50,mask=01, tabulate -> 67 cycles later valid pulse; ch0 x=100,y=50,area=1,found=0; ch1 all zero.
REQ-038 16 pixels mask=10, x=0..15, y=200, tabulate -> ch1 x=7 (120/16 floored), y=200, area=16, found=1.
REQ-039 Pixels y=316 and y=317, mask=11, x=40 -> both channels area=1, y=316.
REQ-040 Tabulate, then tabulate again 10 cycles later with pixels x=8,y=8 in between -> drop pulse; first result unaffected; third tabulate yields x=8,y=8.
REQ-041 rst_n_in low 20 cycles into division -> outputs zero asynchronously, no valid pulse; busy_out=0.
REQ-042 valid_in and tabulate_in same cycle, x=5,y=6,mask=01 only pixel -> ch0 x=5,y=6,area=1; next frame empty.
